// File: rtl/approx_err_monitor.sv
// Measures error statistics of an approximate 16x16 multiplier against the exact product.
// Optional max-error tracking is enabled with macro APPROX_ERR_MONITOR_MAX_EN.
module approx_err_monitor #(
  parameter int N_SAMPLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         A,
  input  logic [15:0]         B,
  input  logic [31:0]         R,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [32+CNT_W-1:0] sum_ed
`ifdef APPROX_ERR_MONITOR_MAX_EN
  ,
  output logic [31:0]         max_ed,
  output logic [15:0]         max_a,
  output logic [15:0]         max_b
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic               clear;
  logic               accept;
  logic [CNT_W-1:0]   acc_cnt;
  logic [1:0]         drain_cnt;

  logic               v1, v2, v3;
  logic [15:0]        a1, b1;
  logic [31:0]        r1, r2, exact2, ed3;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && acc_cnt == CNT_W'(N_SAMPLES - 1)) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Three drain cycles let the last accepted sample reach the accumulators.
        if (drain_cnt == 2'd2) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_n = RUN;
          clear   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (clear)       acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      r1     <= '0;
      r2     <= '0;
      exact2 <= '0;
      ed3    <= '0;
    end else begin
      v1 <= accept & ~clear;
      v2 <= v1 & ~clear;
      v3 <= v2 & ~clear;
      if (accept) begin
        a1 <= A;
        b1 <= B;
        r1 <= R;
      end
      if (v1) begin
        exact2 <= {16'd0, a1} * {16'd0, b1};
        r2     <= r1;
      end
      if (v2) ed3 <= (exact2 >= r2) ? (exact2 - r2) : (r2 - exact2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
    end else if (v3) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (ed3 != 32'd0) err_cnt <= err_cnt + 1'b1;
      sum_ed <= sum_ed + {{CNT_W{1'b0}}, ed3};
    end
  end

`ifdef APPROX_ERR_MONITOR_MAX_EN
  logic [15:0] a2, b2, a3, b3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a2 <= '0;
      b2 <= '0;
      a3 <= '0;
      b3 <= '0;
    end else begin
      if (v1) begin
        a2 <= a1;
        b2 <= b1;
      end
      if (v2) begin
        a3 <= a2;
        b3 <= b2;
      end
    end
  end

  // Strict compare keeps the operands of the first sample that hit the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_ed <= '0;
      max_a  <= '0;
      max_b  <= '0;
    end else if (clear) begin
      max_ed <= '0;
      max_a  <= '0;
      max_b  <= '0;
    end else if (v3 && ed3 > max_ed) begin
      max_ed <= ed3;
      max_a  <= a3;
      max_b  <= b3;
    end
  end
`endif

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1000000: samples per measurement run (1..2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 20: width of sample and error counters.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-006 SHALL have port in_valid, input, 1 bit: A, B and R hold a valid sample.
REQ-007 SHALL have port in_ready, output, 1 bit: the monitor accepts a sample this cycle.
REQ-008 SHALL have port A, input, 16 bits: multiplier operand A.
REQ-009 SHALL have port B, input, 16 bits: multiplier operand B.
REQ-010 SHALL have port R, input, 32 bits: approximate product under test.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.
REQ-012 SHALL have port done, output, 1 bit: high in DONE; results are stable.
REQ-013 SHALL have port sample_cnt, output, CNT_W bits: samples accumulated.
REQ-014 SHALL have port err_cnt, output, CNT_W bits: samples with nonzero error distance.
REQ-015 SHALL have port sum_ed, output, 32+CNT_W bits: sum of error distances.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start.
- RUN->DRAIN on the edge accepting sample N_SAMPLES.
- DRAIN->DONE after exactly 3 cycles.
- DONE->RUN on start.
REQ-017 SHALL drive in_ready=1 only in RUN; a sample is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 SHALL run a 3-stage pipeline:
- edge k: accept and register A, B, R.
- edge k+1: register exact = A*B, unsigned, 32 bits.
- edge k+2: register ED = |exact - R|, 32 bits, no wrap.
- edge k+3: sample_cnt+1; err_cnt+1 if ED!=0; sum_ed+=ED.
REQ-019 SHALL clear sample_cnt, err_cnt and sum_ed on the edge that takes start into RUN, and flush pipeline valid bits on that edge.
REQ-020 SHALL ignore start while busy; a run is not restarted mid-operation.
REQ-021 SHALL accept back-to-back samples every cycle, with no bubble penalty; in_valid gaps only delay the run.
REQ-022 SHALL hold all outputs in DONE until the next start.
REQ-023 SHALL ignore A, B and R when no sample is accepted.
REQ-024 SHALL never accept more than N_SAMPLES samples per run.

Reset
REQ-025 SHALL, on rst, immediately set state=IDLE, in_ready=0, busy=0, done=0, all counters/sums=0 and pipeline valids=0.
REQ-026 SHALL, on rst asserted mid-run, discard in-flight samples; after release the block is IDLE.

Configuration
REQ-027 SHALL, with macro APPROX_ERR_MONITOR_MAX_EN defined, add these outputs:
- max_ed, 32 bits: largest ED this run, updated at the accumulate edge when ED>max_ed.
- max_a, 16 bits: A of the first sample that reached max_ed.
- max_b, 16 bits: B of the same sample.
- All three clear on run start and on reset.
REQ-028 SHALL, without APPROX_ERR_MONITOR_MAX_EN, omit these ports and their logic entirely.

Verification
REQ-029 N_SAMPLES=1; start; sample A=3, B=5, R=15 -> done 4 cycles after accept (3 DRAIN + entry); sample_cnt=1, err_cnt=0, sum_ed=0.
REQ-030 N_SAMPLES=2; samples (65535, 65535, R=0) then (2, 2, R=5) back-to-back -> sum_ed=4294836226, err_cnt=2; with MAX_EN: max_ed=4294836225, max_a=65535, max_b=65535.
REQ-031 N_SAMPLES=4; in_valid toggling 1,0,1,0,... -> exactly 4 samples accepted; in_ready=0 after the 4th; further valid samples are not counted.
REQ-032 start during RUN -> ignored, counters not cleared; rst asserted mid-RUN -> IDLE and zero outputs within the same cycle.
REQ-033 Run of 1000 random samples with R=A*B except 10 forced R=A*B+7 -> err_cnt=10, sum_ed=70, sample_cnt=1000; second start clears all to 0 before accumulating.
